// File: rtl/mod_reg_ser_nto1_if.sv
// -----------------------------------------------------------------------------
// mod_reg_ser_nto1_if
// Block-in / lane-out handshake bundle for the N-to-1 serializer.
//
//   i          N*W  input block, lane k = i[k*W +: W]
//   in_valid   1    i holds a block to load
//   in_ready   1    serializer has a free slot
//   o          W    current output lane
//   out_valid  1    o holds a valid lane
//   out_ready  1    downstream accepts o
//   o_last     1    o is the final lane of its block
//   occ        2    number of blocks held (0..2)
//
// master: the side that supplies blocks and consumes lanes.
// slave : the serializer itself.
// -----------------------------------------------------------------------------
interface mod_reg_ser_nto1_if #(
    parameter int N = 16,
    parameter int W = 8
);
    logic [N*W-1:0] i;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   o;
    logic           out_valid;
    logic           out_ready;
    logic           o_last;
    logic [1:0]     occ;

    modport master (
        output i, in_valid, out_ready,
        input  in_ready, o, out_valid, o_last, occ
    );

    modport slave (
        input  i, in_valid, out_ready,
        output in_ready, o, out_valid, o_last, occ
    );
endinterface

// File: rtl/mod_reg_ser_nto1.sv
// -----------------------------------------------------------------------------
// mod_reg_ser_nto1
// Double-buffered N-to-1 serializer. A whole block of N lanes is captured in
// one cycle into one of two slots; lanes are then emitted one per cycle on a
// valid/ready output. While one slot drains the other can be refilled, so
// consecutive blocks stream without a bubble.
//
// Ports
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   flush    synchronous clear of occupancy, pointers and lane index
//   bus      mod_reg_ser_nto1_if.slave (block input, lane output, occ)
//
// Parameters
//   N          lanes per block (>= 2)
//   W          bits per lane (>= 1)
//   LSB_FIRST  1: lane 0 first, 0: lane N-1 first
// -----------------------------------------------------------------------------
module mod_reg_ser_nto1 #(
    parameter int N         = 16,
    parameter int W         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    mod_reg_ser_nto1_if.slave     bus
);

    localparam int              IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   IDX_LAST = IW'(N - 1);

    logic [N*W-1:0] slot_q [2];
    logic           wp_q, wp_d;
    logic           rp_q, rp_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     occ_q, occ_d;

    logic           in_ready;
    logic           out_valid;
    logic           load;
    logic           xfer;
    logic           retire;
    logic [IW-1:0]  sel;
    logic [W-1:0]   lanes [N];

    // in_ready is decoded from occupancy alone: a full buffer refuses input
    // even in the cycle its head block retires, keeping in_ready free of any
    // combinational path from out_ready.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign load      = bus.in_valid && in_ready;
    assign xfer      = out_valid && bus.out_ready;
    assign retire    = xfer && (idx_q == IDX_LAST);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        idx_d = idx_q;
        occ_d = occ_q;
        if (flush) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            idx_d = '0;
            occ_d = 2'd0;
        end else begin
            if (load) begin
                wp_d = ~wp_q;
            end
            if (xfer) begin
                idx_d = retire ? '0 : idx_q + IW'(1);
            end
            if (retire) begin
                rp_d = ~rp_q;
            end
            // load and retire together leave occupancy unchanged
            occ_d = occ_q + 2'(load) - 2'(retire);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            idx_q     <= '0;
            occ_q     <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            idx_q <= idx_d;
            occ_q <= occ_d;
            if (load && !flush) begin
                slot_q[wp_q] <= bus.i;
            end
        end
    end

    // Lane order is a pure index remap; the slot itself is never shifted.
    assign sel = LSB_FIRST ? idx_q : (IDX_LAST - idx_q);

    always_comb begin
        for (int k = 0; k < N; k++) begin
            lanes[k] = slot_q[rp_q][k*W +: W];
        end
    end

    assign bus.o         = out_valid ? lanes[sel] : '0;
    assign bus.out_valid = out_valid;
    assign bus.o_last    = out_valid && (idx_q == IDX_LAST);
    assign bus.in_ready  = in_ready;
    assign bus.occ       = occ_q;

endmodule

// File: tb/tb_mod_reg_ser_nto1.sv
// -----------------------------------------------------------------------------
// tb_mod_reg_ser_nto1
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// compares both against a queue-of-blocks reference model.
// -----------------------------------------------------------------------------
module tb_mod_reg_ser_nto1;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int GW = W + 5;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    logic           in_valid_r  = 1'b0;
    logic [N*W-1:0] i_r         = '0;
    logic           out_ready_r = 1'b0;

    always #5 clk = ~clk;

    mod_reg_ser_nto1_if #(.N(N), .W(W)) bus_l ();
    mod_reg_ser_nto1_if #(.N(N), .W(W)) bus_m ();

    assign bus_l.i         = i_r;
    assign bus_l.in_valid  = in_valid_r;
    assign bus_l.out_ready = out_ready_r;
    assign bus_m.i         = i_r;
    assign bus_m.in_valid  = in_valid_r;
    assign bus_m.out_ready = out_ready_r;

    mod_reg_ser_nto1 #(.N(N), .W(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .resetn(resetn), .flush(flush), .bus(bus_l.slave));
    mod_reg_ser_nto1 #(.N(N), .W(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .resetn(resetn), .flush(flush), .bus(bus_m.slave));

    int tests_run = 0;
    int fails     = 0;

    // Reference model: blocks waiting or draining, and lanes already sent
    // from the head block.
    logic [N*W-1:0] mq[$];
    int             pos = 0;

    localparam logic [GW-1:0] IDLE = {1'b0, {W{1'b0}}, 1'b0, 2'd0, 1'b1};

    function automatic logic [W-1:0] lane(input logic [N*W-1:0] b, input int k);
        return b[k*W +: W];
    endfunction

    function automatic logic [N*W-1:0] rand_blk();
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = W'($urandom);
        return b;
    endfunction

    // {out_valid, o, o_last, occ, in_ready} expected from the model
    function automatic logic [GW-1:0] expv(input bit lsb);
        int          sz;
        logic [W-1:0] eo;
        sz = mq.size();
        eo = '0;
        if (sz > 0) eo = lane(mq[0], lsb ? pos : N - 1 - pos);
        return {sz > 0, eo, (sz > 0) && (pos == N - 1), 2'(sz), sz < 2};
    endfunction

    function automatic logic [GW-1:0] got_l();
        return {bus_l.out_valid, bus_l.o, bus_l.o_last, bus_l.occ, bus_l.in_ready};
    endfunction

    function automatic logic [GW-1:0] got_m();
        return {bus_m.out_valid, bus_m.o, bus_m.o_last, bus_m.occ, bus_m.in_ready};
    endfunction

    // Apply inputs for one cycle, advance the model at the edge, return at
    // the following falling edge where outputs are sampled.
    task automatic tick(input bit v, input logic [N*W-1:0] d, input bit ordy, input bit fl);
        int sz;
        in_valid_r  = v;
        i_r         = d;
        out_ready_r = ordy;
        flush       = fl;
        @(posedge clk);
        sz = mq.size();
        if (fl) begin
            mq.delete();
            pos = 0;
        end else begin
            if (sz > 0 && ordy) begin
                pos++;
                if (pos == N) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (v && sz < 2) mq.push_back(d);
        end
        @(negedge clk);
        in_valid_r = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        if (got_l() !== IDLE) begin fails++; $display("FAIL reset_l got %h exp %h", got_l(), IDLE); end
        tests_run++;
        if (got_m() !== IDLE) begin fails++; $display("FAIL reset_m got %h exp %h", got_m(), IDLE); end
        tests_run++;
        resetn = 1'b1;
        @(negedge clk);
        if (got_l() !== IDLE) begin fails++; $display("FAIL post_reset got %h exp %h", got_l(), IDLE); end
        tests_run++;
    endtask

    task automatic test_single_block();
        logic [N*W-1:0] blk;
        for (int k = 0; k < N; k++) blk[k*W +: W] = W'(8'h10 + k);
        tick(1'b1, blk, 1'b1, 1'b0);
        for (int c = 0; c < N; c++) begin
            if (bus_l.o !== W'(8'h10 + c) || bus_l.o_last !== (c == N - 1) || bus_l.out_valid !== 1'b1) begin
                fails++; $display("FAIL single_lsb cyc %0d got o=%h last=%b exp o=%h", c, bus_l.o, bus_l.o_last, W'(8'h10 + c));
            end
            tests_run++;
            if (bus_m.o !== W'(8'h1F - c) || bus_m.o_last !== (c == N - 1)) begin
                fails++; $display("FAIL single_msb cyc %0d got o=%h last=%b exp o=%h", c, bus_m.o, bus_m.o_last, W'(8'h1F - c));
            end
            tests_run++;
            if (got_l() !== expv(1'b1)) begin fails++; $display("FAIL single_model cyc %0d got %h exp %h", c, got_l(), expv(1'b1)); end
            tests_run++;
            tick(1'b0, rand_blk(), 1'b1, 1'b0);
        end
        if (got_l() !== IDLE) begin fails++; $display("FAIL single_idle got %h exp %h", got_l(), IDLE); end
        tests_run++;
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] a, b, c;
        a = rand_blk(); b = rand_blk(); c = rand_blk();
        tick(1'b1, a, 1'b0, 1'b0);
        tick(1'b1, b, 1'b0, 1'b0);
        if (bus_l.occ !== 2'd2 || bus_l.in_ready !== 1'b0) begin
            fails++; $display("FAIL full occ=%0d in_ready=%b exp occ=2 in_ready=0", bus_l.occ, bus_l.in_ready);
        end
        tests_run++;
        tick(1'b1, c, 1'b0, 1'b0);
        // C keeps being offered while A and B drain
        for (int k = 0; k < 3 * N + 2; k++) begin
            if (got_l() !== expv(1'b1)) begin fails++; $display("FAIL b2b_l cyc %0d got %h exp %h", k, got_l(), expv(1'b1)); end
            tests_run++;
            if (got_m() !== expv(1'b0)) begin fails++; $display("FAIL b2b_m cyc %0d got %h exp %h", k, got_m(), expv(1'b0)); end
            tests_run++;
            tick(k < N + 1, c, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int xcnt, lcnt;
        bit ordy, v;
        logic [N*W-1:0] d;
        xcnt = 0; lcnt = 0; ordy = 1'b0;
        for (int k = 0; k < 120 + 3 * N; k++) begin
            v = (k < 120) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (k < 120) ? ~ordy : 1'b1;
            d = rand_blk();
            if (got_l() !== expv(1'b1)) begin fails++; $display("FAIL bp_l cyc %0d got %h exp %h", k, got_l(), expv(1'b1)); end
            tests_run++;
            if (got_m() !== expv(1'b0)) begin fails++; $display("FAIL bp_m cyc %0d got %h exp %h", k, got_m(), expv(1'b0)); end
            tests_run++;
            if (bus_l.out_valid && ordy) xcnt++;
            if (v && mq.size() < 2) lcnt++;
            tick(v, d, ordy, 1'b0);
        end
        if (xcnt !== N * lcnt) begin fails++; $display("FAIL bp_count transfers %0d exp %0d", xcnt, N * lcnt); end
        tests_run++;
    endtask

    task automatic test_load_retire();
        logic [N*W-1:0] a, b;
        a = rand_blk(); b = rand_blk();
        tick(1'b1, a, 1'b1, 1'b0);
        for (int k = 0; k < N - 1; k++) tick(1'b0, a, 1'b1, 1'b0);
        if (bus_l.o_last !== 1'b1 || bus_l.occ !== 2'd1) begin
            fails++; $display("FAIL lr_pre last=%b occ=%0d exp last=1 occ=1", bus_l.o_last, bus_l.occ);
        end
        tests_run++;
        tick(1'b1, b, 1'b1, 1'b0);
        if (bus_l.occ !== 2'd1 || bus_l.o !== lane(b, 0) || bus_m.o !== lane(b, N - 1)) begin
            fails++; $display("FAIL lr_post occ=%0d o=%h/%h exp occ=1 o=%h/%h", bus_l.occ, bus_l.o, bus_m.o, lane(b, 0), lane(b, N - 1));
        end
        tests_run++;
        for (int k = 0; k < N + 1; k++) begin
            if (got_l() !== expv(1'b1)) begin fails++; $display("FAIL lr_drain cyc %0d got %h exp %h", k, got_l(), expv(1'b1)); end
            tests_run++;
            tick(1'b0, a, 1'b1, 1'b0);
        end
    endtask

    task automatic test_mid_abort();
        logic [N*W-1:0] a, b;
        for (int mode = 0; mode < 2; mode++) begin
            a = rand_blk(); b = rand_blk();
            tick(1'b1, a, 1'b1, 1'b0);
            for (int k = 0; k < 6; k++) tick(1'b0, a, 1'b1, 1'b0);
            if (bus_l.o !== lane(a, 6)) begin fails++; $display("FAIL abort_pre mode %0d o=%h exp %h", mode, bus_l.o, lane(a, 6)); end
            tests_run++;
            if (mode == 0) begin
                resetn = 1'b0;
                #1;
                mq.delete(); pos = 0;
            end else begin
                // flush with a simultaneous load: both must be discarded
                tick(1'b1, b, 1'b1, 1'b1);
            end
            if (got_l() !== IDLE) begin fails++; $display("FAIL abort_l mode %0d got %h exp %h", mode, got_l(), IDLE); end
            tests_run++;
            if (got_m() !== IDLE) begin fails++; $display("FAIL abort_m mode %0d got %h exp %h", mode, got_m(), IDLE); end
            tests_run++;
            if (mode == 0) begin
                @(negedge clk);
                resetn = 1'b1;
                @(negedge clk);
            end
            tick(1'b1, b, 1'b0, 1'b0);
            if (bus_l.o !== lane(b, 0) || bus_m.o !== lane(b, N - 1) || bus_l.occ !== 2'd1) begin
                fails++; $display("FAIL abort_next mode %0d o=%h/%h occ=%0d exp %h/%h occ=1", mode, bus_l.o, bus_m.o, bus_l.occ, lane(b, 0), lane(b, N - 1));
            end
            tests_run++;
            for (int k = 0; k < N; k++) tick(1'b0, b, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        bit v, ordy, fl;
        for (int k = 0; k < 500; k++) begin
            v    = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            if (got_l() !== expv(1'b1)) begin fails++; $display("FAIL rand_l cyc %0d got %h exp %h", k, got_l(), expv(1'b1)); end
            tests_run++;
            if (got_m() !== expv(1'b0)) begin fails++; $display("FAIL rand_m cyc %0d got %h exp %h", k, got_m(), expv(1'b0)); end
            tests_run++;
            tick(v, rand_blk(), ordy, fl);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_load_retire();
        test_mid_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mod_reg_ser_nto1.md
# mod_reg_ser_nto1

Parametrised, double-buffered N-to-1 serializer for the AES256 datapath. It accepts a whole block of N lanes of W bits in one cycle and emits them one lane per cycle on a valid/ready output. A second block slot lets the next block load while the current one drains, so back-to-back blocks stream without gaps. Default configuration (N=16, W=8) serializes one 128-bit AES state into 16 bytes for the downstream FIFO.

## Interface

Parameters:
- N, 16: lanes per block; N >= 2.
- W, 8: bits per lane; W >= 1.
- LSB_FIRST, 1: 1 emits lane 0 (i[W-1:0]) first; 0 emits lane N-1 first.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both slots and the lane index.
- i  in  N*W  input block; lane k is i[k*W +: W].
- in_valid  in  1  i holds a block to load.
- in_ready  out  1  a free slot exists; the block is taken when in_valid && in_ready.
- o  out  W  current output lane.
- out_valid  out  1  o holds a valid lane.
- out_ready  in  1  downstream accepts o; the lane transfers when out_valid && out_ready.
- o_last  out  1  the current lane is the final lane of its block.
- occ  out  2  number of blocks held: 0, 1 or 2.

## Operation

- Storage: two slots of N*W bits. A write pointer wp and a read pointer rp (1 bit each) select the slots. A lane index idx is $clog2(N) bits wide. occ is 0..2.
- Load: on in_valid && in_ready, slot[wp] <= i and wp toggles. The whole block is captured on that edge.
- in_ready = (occ != 2). It is a pure register decode and does not depend on out_ready. A full buffer therefore refuses input even in the cycle its last lane drains.
- Output path (combinational from registers):
  - out_valid = (occ != 0).
  - o = lane sel(idx) of slot[rp], where sel(idx) = idx when LSB_FIRST=1 and N-1-idx when LSB_FIRST=0.
  - o = 0 whenever occ == 0.
  - o_last = out_valid && (idx == N-1).
- Drain: on each transfer, idx increments. When the transfer has idx == N-1, idx wraps to 0, rp toggles and the block retires.
- occ update each edge: occ + load - retire. A load and a retire in the same cycle leave occ unchanged.
- Stall: while out_valid && !out_ready, o, o_last, idx and rp hold. Input loads may still proceed if occ < 2.
- flush (when resetn is high): occ, idx, wp and rp go to 0. Slot contents need not be cleared. A load or transfer in the same cycle is discarded. flush overrides both handshakes.
- Reset (resetn low, asynchronous): occ=0, idx=0, wp=0, rp=0, slots=0. Outputs at reset: out_valid=0, o=0, o_last=0, occ=0, in_ready=1. A block that is partly drained when reset asserts is lost.
- Protocol: i is sampled only on a load. No assumption is made about i or in_valid while in_ready is low.

## Timing

- Load-to-output latency: a block accepted at edge k has its first lane on o with out_valid=1 in the cycle after edge k. There is no additional pipeline stage.
- Throughput: 1 lane per cycle with out_ready held high. N cycles per block.
- Back-to-back: a second block loaded during the drain of the first appears on the cycle after the first block's o_last transfer. There is no bubble.
- Input acceptance: with out_ready=1 continuously, in_valid can be accepted every cycle until occ reaches 2. After that, it can be accepted once per N cycles.
- occ and in_ready reflect the registered state. Both update on the edge that follows the handshake.

## Test plan

- Reset then single block: N=16, W=8, load i lane k = 8'h10+k, out_ready=1. Expect o = 10,11,...,1F on 16 consecutive cycles starting one cycle after the load, o_last only on 1F, then out_valid=0, o=0, occ=0.
- LSB_FIRST=0 with the same block: expect o = 1F down to 10, with o_last on 10.
- Double buffer and full condition: load blocks A and B on consecutive cycles with out_ready=0. Expect occ=2 and in_ready=0, and a third block C offered is not taken. Then set out_ready=1: expect A's 16 lanes immediately followed by B's, with no bubble. in_ready must remain 0 through the cycle of A's o_last transfer and rise on the following cycle.
- Backpressure: toggle out_ready every cycle. Expect o and o_last to hold while it is low, with no lane skipped or duplicated. Expect exactly 16 transfers per block.
- Simultaneous load and retire: with occ=1, load block B on the cycle A's last lane transfers. Expect occ to stay 1 and B's lane 0 to appear on the next cycle.
- Mid-drain reset and flush: assert resetn=0 after lane 5 of a block, and separately flush=1 after lane 5. In both cases expect out_valid=0, o=0, occ=0 and in_ready=1. The next block loaded must start at its lane 0.
